dsp_inst_decode_pipe: RTL
=========================

// Module: dsp_inst_decode_pipe
// PURPOSE
//  Parametrised, pipelined successor to the combinational instruction decoder for the DSP core.
//  Buffers 32-bit instructions in a small FIFO and decodes them into a registered control bundle.
//  Adds valid/ready flow control, interrupt-wait stalling, illegal-opcode detection and flush.
//  Sits between instruction fetch and the AD/FIR/wavelet/UART/move execution units.
// PARAMETERS
//  N_CH       8   channel/select field width, 1..8; fields are LSB-aligned, upper field bits ignored
//  OPERAND_W  16  operand width, 1..16, taken from inst[OPERAND_W-1:0]
//  FIFO_DEPTH 4   instruction FIFO entries, power of two, >=2
// PORTS
//  clk          in  1          clock; all state changes on the rising edge
//  rst_n        in  1          asynchronous reset, active low
//  flush        in  1          synchronous clear of FIFO, decode register and WAIT state
//  inst_valid   in  1          instruction offered
//  inst_in      in  32         instruction word; opcode = inst_in[31:26]
//  inst_ready   out 1          high when FIFO not full and flush low
//  irq          in  1          interrupt; releases an INT wait
//  ctrl_valid   out 1          decoded bundle valid
//  ctrl_ready   in  1          execution unit accepts bundle
//  ctrl_cls     out 16         one-hot class; bits 0..7 = XBH,XBL,FIR_REG,DES_ADDR,SOR_ADDR,LEN,LR,HR writes;
//                              8 AD, 9 XB, 10 FIR, 11 UARTO, 12 ZLB, 13 MOVE, 14 INT, 15 JC
//  reg_idx      out 3          inst[25:23], register index for write classes
//  operand      out OPERAND_W  inst[OPERAND_W-1:0]
//  channel      out N_CH       inst[16+N_CH-1:16]
//  select       out N_CH       inst[8+N_CH-1:8]
//  source       out 2          inst[25:24]: 10 AD, 00 RAM, 01 DDR, 11 reserved (passed through)
//  des_dir      out 1          inst[25]; des for AD, dir for MOVE
//  waiting      out 1          high in WAIT state
//  illegal      out 1          one-cycle pulse when an illegal opcode is dropped
// BEHAVIOUR
//  Reset: FIFO empty, state RUN; all outputs 0 except inst_ready, which is 1 after reset release.
//  Opcode map: 0x00..0x07 register writes (ctrl_cls bit = opcode); 0x10..0x17 map to bits 8..15.
//    All other opcodes are illegal.
//  Input: push when inst_valid & inst_ready. A full FIFO drives inst_ready=0.
//    There is no pass-through on a simultaneous pop.
//  Decode register loads from the FIFO head when empty, or when ctrl_valid & ctrl_ready.
//    FIFO pop happens in the same cycle as the load.
//  Latency: with the FIFO empty and ctrl_ready=1, an instruction accepted at edge N gives ctrl_valid=1 after edge N+1.
//    Throughput is 1 per cycle.
//  While ctrl_valid & !ctrl_ready, every output field is held stable.
//  ctrl_valid drops after a handshake if nothing is loaded.
//  Illegal head: popped and not loaded; illegal=1 for exactly one cycle; nothing emitted.
//  FSM RUN/WAIT:
//    RUN -> WAIT when an INT (0x16) is at the head and the decode register is free; INT is not yet popped.
//    In WAIT: waiting=1, no load. irq sampled high -> INT loaded, popped, state RUN.
//    irq in RUN is ignored and not latched. irq on the same edge as entering WAIT is not seen; the next cycle is needed.
//  flush: next edge clears FIFO, ctrl_valid, WAIT; inst_ready=0 during flush, so any same-cycle input is dropped.
//    flush has priority over push, pop, irq and handshake.
//  Pointers wrap modulo FIFO_DEPTH; a log2(FIFO_DEPTH)+1-bit count distinguishes full from empty.
//  Reset asserted mid-operation clears everything immediately, independent of clk.
// CONFIGURATION
//  DEC_STATS_EN defined:
//    Adds out inst_cnt[15:0] (counts ctrl handshakes, wraps) and illegal_cnt[7:0] (counts illegal pulses, saturates at 255).
//    Both reset to 0 and are cleared by flush.
//  Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  T1: push 0x4A053C00, ctrl_ready=1 -> after 2 edges ctrl_cls=0x0400 (FIR), source=2, channel=0x05, select=0x3C.
//  T2: push 0x14001234 while ctrl_ready=0 for 3 cycles -> ctrl_cls=0x0020, operand=0x1234 held stable.
//    Bundle is accepted once ctrl_ready rises.
//  T3: push 0x58000000 then 0x4A053C00 -> waiting=1, no ctrl_valid. irq pulse -> ctrl_cls=0x4000 (INT), then FIR.
//  T4: push 0xFC000000 -> illegal=1 for one cycle, no ctrl_valid; illegal_cnt=1 with DEC_STATS_EN.
//  T5: ctrl_ready=0, push FIFO_DEPTH+1 words -> inst_ready=0 after FIFO_DEPTH+1 accepts (4 FIFO + 1 decode reg).
//    Order is preserved on drain.
//  T6: flush in WAIT with a full FIFO -> next cycle waiting=0, ctrl_valid=0, inst_ready=1; async rst_n mid-burst clears all.

Source files
------------

// File: rtl/dsp_inst_decode_pipe.sv
// Pipelined DSP instruction decoder: instruction FIFO, registered control bundle, INT wait FSM.
// Optional handshake/illegal statistics counters are enabled by defining DEC_STATS_EN.
module dsp_inst_decode_pipe #(
  parameter int N_CH       = 8,
  parameter int OPERAND_W  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 inst_valid,
  input  logic [31:0]          inst_in,
  output logic                 inst_ready,
  input  logic                 irq,
  output logic                 ctrl_valid,
  input  logic                 ctrl_ready,
  output logic [15:0]          ctrl_cls,
  output logic [2:0]           reg_idx,
  output logic [OPERAND_W-1:0] operand,
  output logic [N_CH-1:0]      channel,
  output logic [N_CH-1:0]      select,
  output logic [1:0]           source,
  output logic                 des_dir,
  output logic                 waiting,
  output logic                 illegal
`ifdef DEC_STATS_EN
  ,
  output logic [15:0]          inst_cnt,
  output logic [7:0]           illegal_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  state_t        state_reg;
  logic          valid_reg;
  logic          illegal_reg;
  logic [31:0]   word_reg;
  logic [15:0]   cls_reg;

  logic [31:0] head;
  logic [5:0]  head_op;
  logic        fifo_empty, fifo_full;
  logic        head_legal, head_is_int;
  logic        slot_free, head_go;
  logic        push, pop, load, drop, enter_wait, handshake;
  logic [15:0] cls_next;

  assign head        = fifo_mem[rd_ptr_reg];
  assign head_op     = head[31:26];
  assign fifo_empty  = (count_reg == '0);
  assign fifo_full   = (count_reg == (AW+1)'(FIFO_DEPTH));
  // Legal opcodes are 0x00..0x07 and 0x10..0x17: bits 5 and 3 both clear.
  assign head_legal  = !head_op[5] && !head_op[3];
  assign head_is_int = (head_op == 6'h16);

  assign inst_ready  = !fifo_full && !flush;
  assign push        = inst_valid && inst_ready;
  assign handshake   = valid_reg && ctrl_ready;
  assign slot_free   = !valid_reg || ctrl_ready;

  // The head is only considered in RUN; in WAIT the parked INT waits for irq.
  assign head_go     = !fifo_empty && slot_free && (state_reg == ST_RUN);
  assign drop        = head_go && !head_legal;
  assign enter_wait  = head_go && head_legal && head_is_int;
  assign load        = (head_go && head_legal && !head_is_int) ||
                       ((state_reg == ST_WAIT) && irq && !fifo_empty);
  assign pop         = load || drop;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_cls
      assign cls_next[gi] = head_legal && ({head_op[4], head_op[2:0]} == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= inst_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      state_reg   <= ST_RUN;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      word_reg    <= '0;
      cls_reg     <= '0;
    end else if (flush) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      state_reg   <= ST_RUN;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= AW'(wr_ptr_reg + 1'b1);
      end
      if (pop) begin
        rd_ptr_reg <= AW'(rd_ptr_reg + 1'b1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + (AW+1)'(1);
      end else if (!push && pop) begin
        count_reg <= count_reg - (AW+1)'(1);
      end

      if (load) begin
        valid_reg <= 1'b1;
        word_reg  <= head;
        cls_reg   <= cls_next;
      end else if (handshake) begin
        valid_reg <= 1'b0;
      end

      illegal_reg <= drop;

      case (state_reg)
        ST_RUN:  if (enter_wait) state_reg <= ST_WAIT;
        ST_WAIT: if (irq) state_reg <= ST_RUN;
        default: state_reg <= ST_RUN;
      endcase
    end
  end

`ifdef DEC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_cnt    <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      inst_cnt    <= '0;
      illegal_cnt <= '0;
    end else begin
      if (handshake) begin
        inst_cnt <= inst_cnt + 16'd1;
      end
      if (drop && (illegal_cnt != 8'hFF)) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end
`endif

  assign ctrl_valid = valid_reg;
  assign ctrl_cls   = cls_reg;
  assign reg_idx    = word_reg[25:23];
  assign operand    = word_reg[OPERAND_W-1:0];
  assign channel    = word_reg[16 +: N_CH];
  assign select     = word_reg[8 +: N_CH];
  assign source     = word_reg[25:24];
  assign des_dir    = word_reg[25];
  assign waiting    = (state_reg == ST_WAIT);
  assign illegal    = illegal_reg;

  // Opcode and any field bits above N_CH/OPERAND_W are intentionally not exported.
  logic unused_word;
  assign unused_word = ^word_reg;

endmodule
